fifo_fwft_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the generated synchronous FIFO wrapper. It converts the FIFO's standard-mode read port into a valid/ready stream with first-word-fall-through behaviour and full one-word-per-cycle throughput. The FIFO is built with no output register, so `fifo_rd_data` is valid one cycle after `fifo_rd_en`. A 2-entry skid buffer absorbs that latency and any back-pressure. The block also marks burst boundaries and counts delivered beats for the downstream burst master.

---
 rtl/fifo_fwft_rd_stream.sv | 99 +++++++++
 tb/tb_fifo_fwft_rd_stream.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_rd_stream.sv
// Read-side adapter: turns a standard-mode (1-cycle latency) FIFO read port into a
// first-word-fall-through valid/ready stream with burst marking and a beat counter.
module fifo_fwft_rd_stream #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_BURST_LEN  = 256,
  parameter int c_CNT_WIDTH  = 32
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  output logic                    fifo_rd_en,
  input  logic                    fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic [c_CNT_WIDTH-1:0]  beat_cnt,
  output logic [1:0]              buf_level
);

  localparam int unsigned c_BIDX_WIDTH = (c_BURST_LEN > 1) ? $clog2(c_BURST_LEN) : 1;
  localparam logic [c_BIDX_WIDTH-1:0] c_LAST_IDX = c_BIDX_WIDTH'(c_BURST_LEN - 1);

  logic [c_DATA_WIDTH-1:0] head_q, head_d;
  logic [c_DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]              level_q, level_d;
  logic                    inflight_q, inflight_d;
  logic [c_BIDX_WIDTH-1:0] bidx_q, bidx_d;
  logic [c_CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       pop;
  logic       push;
  logic [1:0] level_after_pop;
  logic [2:0] occ_after;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    pop             = (level_q != 2'd0) & m_ready;
    push            = inflight_q;
    level_after_pop = level_q - {1'b0, pop};
    // Occupancy the buffer will need once everything already requested has landed.
    occ_after       = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en      = ~rd_rst & ~fifo_rd_empty & (occ_after < 3'd2);
    inflight_d      = fifo_rd_en;

    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      head_d = tail_q;
    end
    // The arriving word goes to the first slot left free after this cycle's pop.
    if (push) begin
      if (level_after_pop == 2'd0) begin
        head_d = fifo_rd_data;
      end else begin
        tail_d = fifo_rd_data;
      end
    end

    bidx_d = bidx_q;
    cnt_d  = cnt_q;
    if (pop) begin
      cnt_d  = cnt_q + 1'b1;
      bidx_d = (bidx_q == c_LAST_IDX) ? '0 : bidx_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      level_q    <= 2'd0;
      inflight_q <= 1'b0;
      bidx_q     <= '0;
      cnt_q      <= '0;
    end else begin
      level_q    <= level_d;
      inflight_q <= inflight_d;
      bidx_q     <= bidx_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: the data slots carry no reset; level_q alone decides whether they hold
  // anything meaningful, so resetting them would only add fan-out.
  always_ff @(posedge rd_clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign m_valid   = (level_q != 2'd0);
  assign m_data    = head_q;
  assign m_last    = m_valid & (bidx_q == c_LAST_IDX);
  assign beat_cnt  = cnt_q;
  assign buf_level = level_q;

endmodule

// File: tb/tb_fifo_fwft_rd_stream.sv
// Bench for fifo_fwft_rd_stream: a queue-based FIFO and stream model drive two
// instances (burst 4 / 4-bit counter, burst 1 / 32-bit counter) sharing one FIFO.
module tb_fifo_fwft_rd_stream;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_ready;
  logic          fifo_rd_empty;
  logic [DW-1:0] fifo_rd_data;

  logic          rd_en_a, valid_a, last_a;
  logic [DW-1:0] data_a;
  logic [3:0]    cnt_a;
  logic [1:0]    lvl_a;
  logic          rd_en_b, valid_b, last_b;
  logic [DW-1:0] data_b;
  logic [31:0]   cnt_b;
  logic [1:0]    lvl_b;

  always #5 clk = ~clk;

  fifo_fwft_rd_stream #(.c_DATA_WIDTH(DW), .c_BURST_LEN(4), .c_CNT_WIDTH(4)) u_dut_a (
    .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_a), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_data(fifo_rd_data), .m_valid(valid_a), .m_ready(m_ready), .m_data(data_a),
    .m_last(last_a), .beat_cnt(cnt_a), .buf_level(lvl_a));

  fifo_fwft_rd_stream #(.c_DATA_WIDTH(DW), .c_BURST_LEN(1), .c_CNT_WIDTH(32)) u_dut_b (
    .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en_b), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_data(fifo_rd_data), .m_valid(valid_b), .m_ready(m_ready), .m_data(data_b),
    .m_last(last_b), .beat_cnt(cnt_b), .buf_level(lvl_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model: FIFO contents, words held downstream, one word in flight.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_buf[$];
  bit            exp_inflight;
  logic [DW-1:0] exp_inflight_word;
  int            exp_beats;
  logic [DW-1:0] wr_next;
  logic [DW-1:0] next_seq;
  int            rd_en_count;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  logic          s_valid, s_rd_en, s_last, s_last_b;
  logic [DW-1:0] s_data;
  logic [1:0]    s_lvl;
  logic [3:0]    s_cnt_a;
  logic [31:0]   s_cnt_b;

  typedef struct {
    logic          rdy;
    logic          valid;
    logic [DW-1:0] data;
    logic          rd_en;
    logic [1:0]    lvl;
    logic          last;
    logic [3:0]    cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic valid, input int data,
                              input logic rd_en, input int lvl, input logic last,
                              input int cnt);
    vec_t v;
    v.rdy   = rdy;
    v.valid = valid;
    v.data  = DW'(data);
    v.rd_en = rd_en;
    v.lvl   = 2'(lvl);
    v.last  = last;
    v.cnt   = 4'(cnt);
    return v;
  endfunction

  function automatic bit busy();
    return (exp_buf.size() != 0) || exp_inflight || (fifo_q.size() != 0);
  endfunction

  task automatic fifo_write(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(wr_next);
      wr_next++;
    end
    fifo_rd_empty = (fifo_q.size() == 0);
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge against the
  // model, then after the rising edge advance the FIFO and the model.
  task automatic cycle(input logic rdy, input logic do_rst);
    bit pop;
    bit exp_rd_en;
    int lvl;
    bit sampled_rd_en;
    pop     = 1'b0;
    m_ready = rdy;
    rst     = do_rst;
    @(negedge clk);
    s_valid = valid_a; s_data = data_a; s_rd_en = rd_en_a; s_lvl = lvl_a;
    s_last = last_a; s_last_b = last_b; s_cnt_a = cnt_a; s_cnt_b = cnt_b;
    if (do_rst) begin
      check("rd_en_in_reset", {rd_en_a, rd_en_b}, 2'b00);
    end else begin
      lvl       = exp_buf.size();
      pop       = (lvl != 0) && rdy;
      exp_rd_en = (fifo_q.size() != 0) && (lvl + int'(exp_inflight) - int'(pop) < 2);
      check("m_valid", valid_a, lvl != 0);
      check("m_valid_b", valid_b, lvl != 0);
      check("buf_level", lvl_a, lvl);
      check("buf_level_b", lvl_b, lvl);
      check("fifo_rd_en", rd_en_a, exp_rd_en);
      check("fifo_rd_en_b", rd_en_b, exp_rd_en);
      if (lvl != 0) begin
        check("m_data", data_a, exp_buf[0]);
        check("m_data_b", data_b, exp_buf[0]);
      end
      if (pop) check("order", data_a, next_seq);
      check("m_last_bl4", last_a, (lvl != 0) && (exp_beats % 4 == 3));
      check("m_last_bl1", last_b, lvl != 0);
      check("beat_cnt_w4", cnt_a, exp_beats % 16);
      check("beat_cnt_w32", cnt_b, exp_beats);
      if (prev_stall) begin
        check("stall_data_stable", data_a, prev_data);
        check("stall_last_stable", last_a, prev_last);
      end
    end
    prev_stall    = !do_rst && valid_a && !rdy;
    prev_data     = data_a;
    prev_last     = last_a;
    sampled_rd_en = rd_en_a;
    @(posedge clk);
    #1;
    if (do_rst) begin
      fifo_q.delete();
      exp_buf.delete();
      exp_inflight  = 1'b0;
      exp_beats     = 0;
      next_seq      = wr_next;
      fifo_rd_empty = 1'b1;
      prev_stall    = 1'b0;
    end else begin
      if (pop) begin
        exp_buf.delete(0);
        exp_beats++;
        next_seq++;
      end
      if (exp_inflight) exp_buf.push_back(exp_inflight_word);
      exp_inflight = sampled_rd_en;
      if (sampled_rd_en) begin
        rd_en_count++;
        if (fifo_q.size() != 0) begin
          fifo_rd_data = fifo_q.pop_front();
        end
        exp_inflight_word = fifo_rd_data;
      end
      fifo_rd_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy() && n < 200) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check(name, n < 200, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int lvl2_seen;
    int n;
    logic [DW-1:0] first_new;

    rst = 1'b1; m_ready = 1'b0; fifo_rd_empty = 1'b1; fifo_rd_data = '0;
    exp_inflight = 1'b0; exp_inflight_word = '0; exp_beats = 0;
    wr_next = '0; next_seq = '0; rd_en_count = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;

    // Streaming 0..9 with m_ready held high; columns: rdy valid data rd_en lvl last cnt.
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(1, 1, 1, 1, 1, 0, 1);
    tbl[4]  = mk(1, 1, 2, 1, 1, 0, 2);
    tbl[5]  = mk(1, 1, 3, 1, 1, 1, 3);
    tbl[6]  = mk(1, 1, 4, 1, 1, 0, 4);
    tbl[7]  = mk(1, 1, 5, 1, 1, 0, 5);
    tbl[8]  = mk(1, 1, 6, 1, 1, 0, 6);
    tbl[9]  = mk(1, 1, 7, 1, 1, 1, 7);
    tbl[10] = mk(1, 1, 8, 0, 1, 0, 8);
    tbl[11] = mk(1, 1, 9, 0, 1, 0, 9);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 10);

    do_reset();
    cycle(1'b0, 1'b0);
    check("reset_valid", s_valid, 1'b0);
    check("reset_last", s_last, 1'b0);
    check("reset_cnt", s_cnt_b, 0);
    check("reset_level", s_lvl, 0);

    fifo_write(10);
    for (int k = 0; k < 13; k++) begin
      cycle(tbl[k].rdy, 1'b0);
      check("tbl_valid", s_valid, tbl[k].valid);
      if (tbl[k].valid) check("tbl_data", s_data, tbl[k].data);
      check("tbl_rd_en", s_rd_en, tbl[k].rd_en);
      check("tbl_level", s_lvl, tbl[k].lvl);
      check("tbl_last", s_last, tbl[k].last);
      check("tbl_last_bl1", s_last_b, tbl[k].valid);
      check("tbl_cnt", s_cnt_a, tbl[k].cnt);
    end

    // Random back-pressure over 100 words.
    do_reset();
    sent = 0;
    lvl2_seen = 0;
    for (int i = 0; i < 3000 && (sent < 100 || busy()); i++) begin
      cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 1'b0);
      if (s_lvl == 2'd2) lvl2_seen++;
      if (sent < 100 && $urandom_range(0, 3) != 0) begin
        fifo_write(1);
        sent++;
      end
    end
    check("bp_drained", busy(), 1'b0);
    cycle(1'b0, 1'b0);
    check("bp_beat_cnt", s_cnt_b, 100);
    check("bp_beat_cnt_w4", s_cnt_a, 100 % 16);
    check("bp_level_zero", s_lvl, 0);
    check("bp_level2_reached", lvl2_seen > 0, 1'b1);

    // Isolated words, 5 cycles apart: one read strobe each.
    do_reset();
    rd_en_count = 0;
    for (int w = 0; w < 4; w++) begin
      fifo_write(1);
      repeat (5) cycle(1'b1, 1'b0);
    end
    check("single_word_reads", rd_en_count, 4);

    // Reset while a word is buffered and another is in flight, downstream stalled.
    do_reset();
    fifo_write(6);
    n = 0;
    while (!(exp_buf.size() == 1 && exp_inflight) && n < 20) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check("mid_reset_setup", n < 20, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("mid_reset_valid", s_valid, 1'b0);
    check("mid_reset_cnt", s_cnt_b, 0);
    check("mid_reset_level", s_lvl, 0);
    first_new = wr_next;
    fifo_write(5);
    n = 0;
    do begin
      cycle(1'b1, 1'b0);
      n++;
    end while (!s_valid && n < 10);
    check("first_after_reset", s_data, first_new);
    drain("mid_reset_drain");

    // 18 beats through a 4-bit counter.
    do_reset();
    fifo_write(18);
    drain("wrap_drain");
    cycle(1'b0, 1'b0);
    check("wrap_cnt_w4", s_cnt_a, 2);
    check("wrap_cnt_w32", s_cnt_b, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
